pipe_stage_skid: RTL and testbench

Parametrised elastic pipeline stage that replaces the fixed-width enable-only pipeline register between CPU stages (IF/ID, ID/EX, EX/MEM, MEM/WB). It uses a valid/ready handshake with a two-entry skid buffer, so in_ready is registered and has no combinational path from out_ready. It adds a synchronous flush for bubble insertion on branch mispredict, an occupancy output, and a saturating stall-cycle counter for the hazard unit and performance debug.

---
 rtl/pipe_stage_skid.sv | 114 +++++++++++
 tb/tb_pipe_stage_skid.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_skid.sv
// Elastic pipeline stage with a two-entry skid buffer, flush for bubble insertion,
// occupancy report and a saturating stall-cycle counter.
module pipe_stage_skid #(
    parameter int WIDTH          = 70,
    parameter bit CLEAR_ON_FLUSH = 1'b1,
    parameter int CNT_W          = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       occupancy,
    output logic [CNT_W-1:0] stall_cnt,
    input  logic             stall_clr
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] main_q;
    logic [WIDTH-1:0] skid_q;
    logic [WIDTH-1:0] main_next;
    logic [WIDTH-1:0] skid_next;
    logic             in_ready_q;
    logic             acc;
    logic             take;

    assign acc  = in_valid & in_ready_q;
    assign take = out_valid & out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= EMPTY;
            main_q     <= '0;
            skid_q     <= '0;
            in_ready_q <= 1'b1;
        end else begin
            state      <= state_next;
            main_q     <= main_next;
            skid_q     <= skid_next;
            in_ready_q <= (state_next != TWO);
        end
    end

    // The skid entry always drains into main, so main is the oldest payload.
    always_comb begin
        state_next = state;
        main_next  = main_q;
        skid_next  = skid_q;
        if (flush) begin
            state_next = EMPTY;
            if (CLEAR_ON_FLUSH) begin
                main_next = '0;
                skid_next = '0;
            end
        end else begin
            unique case (state)
                EMPTY: begin
                    if (acc) begin
                        state_next = ONE;
                        main_next  = in_data;
                    end
                end
                ONE: begin
                    if (acc && take) begin
                        main_next = in_data;
                    end else if (acc) begin
                        state_next = TWO;
                        skid_next  = in_data;
                    end else if (take) begin
                        state_next = EMPTY;
                    end
                end
                TWO: begin
                    if (take) begin
                        state_next = ONE;
                        main_next  = skid_q;
                    end
                end
                default: state_next = EMPTY;
            endcase
        end
    end

    always_comb begin
        out_valid = (state != EMPTY);
        in_ready  = in_ready_q;
        out_data  = main_q;
        occupancy = state;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (stall_clr) begin
            stall_cnt <= '0;
        end else if (in_valid && !in_ready_q && (stall_cnt != CNT_MAX)) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: directed scenarios plus randomized traffic, checked
// against a queue-based model of the stage contents.
module tb_pipe_stage_skid;

    localparam int WIDTH   = 70;
    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk;
    logic             rst_n;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [1:0]       occupancy;
    logic [CNT_W-1:0] stall_cnt;
    logic             stall_clr;

    pipe_stage_skid #(
        .WIDTH         (WIDTH),
        .CLEAR_ON_FLUSH(1'b1),
        .CNT_W         (CNT_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .occupancy(occupancy),
        .stall_cnt(stall_cnt),
        .stall_clr(stall_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int               tests_run = 0;
    int               tests_failed = 0;
    logic [WIDTH-1:0] model_q[$];
    int               model_stall;
    bit               model_zero;
    bit               last_acc;

    task automatic checkOutput(input string tag, input logic [127:0] observed,
                               input logic [127:0] expected);
        tests_run++;
        if (observed !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, observed, expected, $time);
        end
    endtask

    function automatic void model_reset();
        model_q.delete();
        model_stall = 0;
        model_zero  = 1'b1;
    endfunction

    task automatic check_all();
        checkOutput("out_valid", out_valid, model_q.size() > 0);
        checkOutput("in_ready", in_ready, model_q.size() < 2);
        checkOutput("occupancy", occupancy, model_q.size());
        checkOutput("stall_cnt", stall_cnt, model_stall);
        if (model_q.size() > 0)
            checkOutput("out_data", out_data, model_q[0]);
        else if (model_zero)
            checkOutput("out_data_cleared", out_data, 0);
    endtask

    // One clock of stimulus: drive after the falling edge, update the model at the
    // rising edge, compare at the next falling edge.
    task automatic applyStimulus(input bit iv, input logic [WIDTH-1:0] data, input bit ordy,
                                 input bit fl, input bit clr);
        bit acc;
        bit take;
        bit stalled;
        in_valid  = iv;
        in_data   = data;
        out_ready = ordy;
        flush     = fl;
        stall_clr = clr;
        acc       = iv && (model_q.size() < 2);
        take      = ordy && (model_q.size() > 0);
        stalled   = iv && (model_q.size() == 2);
        @(posedge clk);
        if (clr) model_stall = 0;
        else if (stalled && model_stall < CNT_MAX) model_stall++;
        if (fl) begin
            model_q.delete();
            model_zero = 1'b1;
        end else begin
            if (take) model_q.delete(0);
            if (acc) begin
                model_q.push_back(data);
                model_zero = 1'b0;
            end
        end
        last_acc = acc && !fl;
        @(negedge clk);
        check_all();
    endtask

    task automatic idle(input bit ordy);
        applyStimulus(1'b0, '0, ordy, 1'b0, 1'b0);
    endtask

    logic [95:0]      rnd;
    logic [WIDTH-1:0] rdata;

    initial begin
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        stall_clr = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check_all();
        rst_n = 1'b1;

        $display("[TB] streaming 0x1..0x5");
        for (int k = 1; k <= 5; k++) begin
            applyStimulus(1'b1, WIDTH'(k), 1'b1, 1'b0, 1'b0);
            checkOutput("stream_data", out_data, k);
            checkOutput("stream_occ", occupancy, 1);
        end
        idle(1'b1);

        $display("[TB] fill and block");
        applyStimulus(1'b1, WIDTH'('hA), 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, WIDTH'('hB), 1'b0, 1'b0, 1'b0);
        checkOutput("block_in_ready", in_ready, 0);
        checkOutput("block_occ", occupancy, 2);
        for (int k = 1; k <= 3; k++) begin
            applyStimulus(1'b1, WIDTH'('hC), 1'b0, 1'b0, 1'b0);
            checkOutput("block_stall", stall_cnt, k);
        end
        begin
            logic [WIDTH-1:0] seen[$];
            bit c_taken = 1'b0;
            for (int k = 0; k < 8; k++) begin
                if (out_valid) seen.push_back(out_data);
                if (!c_taken) begin
                    applyStimulus(1'b1, WIDTH'('hC), 1'b1, 1'b0, 1'b0);
                    c_taken = last_acc;
                end else begin
                    idle(1'b1);
                end
            end
            checkOutput("drain_count", seen.size(), 3);
            if (seen.size() == 3) begin
                checkOutput("drain_0", seen[0], 'hA);
                checkOutput("drain_1", seen[1], 'hB);
                checkOutput("drain_2", seen[2], 'hC);
            end
        end
        applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b1);

        $display("[TB] flush while full");
        applyStimulus(1'b1, WIDTH'('h11), 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, WIDTH'('h22), 1'b0, 1'b0, 1'b0);
        checkOutput("flush_pre_data", out_data, 'h11);
        applyStimulus(1'b0, '0, 1'b1, 1'b1, 1'b0);
        checkOutput("flush_valid", out_valid, 0);
        checkOutput("flush_data", out_data, 0);
        checkOutput("flush_occ", occupancy, 0);
        idle(1'b1);

        $display("[TB] flush with accept from empty");
        applyStimulus(1'b1, WIDTH'('h33), 1'b1, 1'b1, 1'b0);
        checkOutput("flush_acc_valid", out_valid, 0);
        idle(1'b1);
        checkOutput("flush_acc_valid2", out_valid, 0);

        $display("[TB] stall counter saturation");
        applyStimulus(1'b1, WIDTH'('h44), 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < (1 << CNT_W) + 5; k++)
            applyStimulus(1'b1, WIDTH'('h55), 1'b0, 1'b0, 1'b0);
        checkOutput("stall_sat", stall_cnt, CNT_MAX);
        applyStimulus(1'b1, WIDTH'('h55), 1'b0, 1'b0, 1'b1);
        checkOutput("stall_clr", stall_cnt, 0);

        $display("[TB] asynchronous reset while full");
        checkOutput("pre_reset_occ", occupancy, 2);
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("areset_valid", out_valid, 0);
        checkOutput("areset_occ", occupancy, 0);
        checkOutput("areset_ready", in_ready, 1);
        checkOutput("areset_stall", stall_cnt, 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            applyStimulus(1'b1, WIDTH'(k + 'h60), 1'b1, 1'b0, 1'b0);
            checkOutput("post_reset_data", out_data, k + 'h60);
        end

        $display("[TB] randomized traffic");
        for (int k = 0; k < 400; k++) begin
            rnd   = {$urandom(), $urandom(), $urandom()};
            rdata = rnd[WIDTH-1:0];
            applyStimulus($urandom_range(0, 3) != 0, rdata, $urandom_range(0, 2) != 0,
                          $urandom_range(0, 15) == 0, $urandom_range(0, 31) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
